// File: rtl/comp_argmax_ctrl.sv
// Streaming arg-max sequencer around one comp_cmp16 magnitude comparator.
// Optional build macro: CMP_TIE_LAST_EN (last equal maximum wins instead of the first).

module comp_cmp16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [2:0]  result
);
    // One-hot compare: [2] a==b, [1] a>b, [0] a<b
    always_comb begin
        result = 3'b000;
        if (a == b) begin
            result = 3'b100;
        end else if (a > b) begin
            result = 3'b010;
        end else begin
            result = 3'b001;
        end
    end
endmodule

module comp_argmax_ctrl #(
    parameter int D_WIDTH = 16,
    parameter int N_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_WIDTH-1:0] len,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] in_data,
    output logic               busy,
    output logic               done,
    output logic [D_WIDTH-1:0] max_val,
    output logic [N_WIDTH-1:0] max_idx
);
    if (D_WIDTH != 16) begin : g_bad_width
        $error("comp_argmax_ctrl: D_WIDTH must be 16 to match comp_cmp16");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [N_WIDTH-1:0] N_ZERO = {N_WIDTH{1'b0}};
    localparam logic [N_WIDTH-1:0] N_ONE  = {{(N_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [D_WIDTH-1:0] D_ZERO = {D_WIDTH{1'b0}};

    state_t             state_q, state_d;
    logic [N_WIDTH-1:0] len_q, len_d;
    logic [N_WIDTH-1:0] cnt_q, cnt_d;
    logic [D_WIDTH-1:0] max_val_q, max_val_d;
    logic [N_WIDTH-1:0] max_idx_q, max_idx_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2:0]         cmp_res_s;
    logic               accept_s;
    logic               upd_s;

    comp_cmp16 u_cmp (
        .a      (in_data),
        .b      (max_val_q),
        .result (cmp_res_s)
    );

    // Decide whether an accepted beat replaces the running maximum
    always_comb begin
`ifdef CMP_TIE_LAST_EN
        upd_s = (cmp_res_s[1] || cmp_res_s[2]) && !cmp_res_s[0];
`else
        upd_s = cmp_res_s[1] && !cmp_res_s[2] && !cmp_res_s[0];
`endif
    end

    // Next-state and datapath update; outputs are derived from the next state so they register cleanly
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        accept_s  = in_valid && in_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != N_ZERO) begin
                        len_d   = len;
                        cnt_d   = N_ZERO;
                        state_d = ST_LOAD;
                    end else begin
                        max_val_d = D_ZERO;
                        max_idx_d = N_ZERO;
                        state_d   = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    max_val_d = D_ZERO;
                    max_idx_d = N_ZERO;
                    state_d   = ST_IDLE;
                end else if (accept_s) begin
                    max_val_d = in_data;
                    max_idx_d = N_ZERO;
                    cnt_d     = N_ONE;
                    state_d   = (len_q == N_ONE) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    max_val_d = D_ZERO;
                    max_idx_d = N_ZERO;
                    state_d   = ST_IDLE;
                end else if (accept_s) begin
                    if (upd_s) begin
                        max_val_d = in_data;
                        max_idx_d = cnt_q;
                    end else begin
                        max_val_d = max_val_q;
                    end
                    cnt_d = cnt_q + N_ONE;
                    // len_q >= 2 here, so cnt never passes len_q-1 and never wraps
                    if (cnt_q == len_q - N_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
        busy_d     = (state_d == ST_LOAD) || (state_d == ST_RUN);
        done_d     = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= N_ZERO;
            cnt_q      <= N_ZERO;
            max_val_q  <= D_ZERO;
            max_idx_q  <= N_ZERO;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            max_val_q  <= max_val_d;
            max_idx_q  <= max_idx_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign max_val  = max_val_q;
    assign max_idx  = max_idx_q;
endmodule

// File: tb/tb_comp_argmax_ctrl.sv
// Self-checking bench for comp_argmax_ctrl: directed vector table, random runs
// against an arg-max reference model, and hand sequences for abort and reset.

module tb_comp_argmax_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  len = 5'd0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'd0;
    logic        busy;
    logic        done;
    logic [15:0] max_val;
    logic [4:0]  max_idx;

    int checks = 0;
    int errors = 0;
    logic [15:0] stim [32];

`ifdef CMP_TIE_LAST_EN
    localparam bit TIE_LAST = 1'b1;
`else
    localparam bit TIE_LAST = 1'b0;
`endif

    comp_argmax_ctrl #(.D_WIDTH(16), .N_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .busy(busy), .done(done), .max_val(max_val), .max_idx(max_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int              len;
        int              vprob;
        logic [15:0][15:0] d;
        logic [15:0]     ev;
        logic [4:0]      ei;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: arg-max over the first L stimulus words
    function automatic void model(input int L, output logic [15:0] v, output logic [4:0] i);
        v = 16'd0;
        i = 5'd0;
        for (int k = 0; k < L; k++) begin
            if (k == 0 || stim[k] > v || (TIE_LAST && stim[k] == v)) begin
                v = stim[k];
                i = 5'(k);
            end
        end
    endfunction

    // Run one transfer of stim[0..L-1]; returns results, accept count, cycles to done
    task automatic do_run(input int L, input int vprob, output logic [15:0] v,
                          output logic [4:0] i, output int acc, output int cyc,
                          output bit saw_ready, output bit got);
        int k;
        k = 0; acc = 0; cyc = 0; saw_ready = 1'b0; got = 1'b0;
        v = 16'd0; i = 5'd0;
        @(negedge clk);
        start = 1'b1;
        len = 5'(L);
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) begin
                v = max_val; i = max_idx; got = 1'b1;
                chk("ready_at_done", {31'd0, in_ready}, 32'd0);
                break;
            end
            if (in_ready) saw_ready = 1'b1;
            in_valid = (vprob >= 100) || (int'($urandom_range(99)) < vprob);
            in_data = (k < L) ? stim[k] : 16'($urandom);
            if (in_valid && in_ready) begin
                k++;
                acc++;
            end
        end
        in_valid = 1'b0;
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL done_timeout actual=0 required=1");
        end
    endtask

    task automatic run_and_check(input string tag, input int L, input int vprob,
                                 input logic [15:0] ev, input logic [4:0] ei);
        logic [15:0] v;
        logic [4:0]  i;
        int acc, cyc;
        bit saw, got;
        do_run(L, vprob, v, i, acc, cyc, saw, got);
        if (got) begin
            chk({tag, "_max_val"}, {16'd0, v}, {16'd0, ev});
            chk({tag, "_max_idx"}, {27'd0, i}, {27'd0, ei});
            chk({tag, "_accepts"}, acc, L);
            if (vprob >= 100) chk({tag, "_latency"}, cyc, L + 1);
            if (L == 0) chk({tag, "_ready_len0"}, {31'd0, saw}, 32'd0);
            @(negedge clk);
            chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
            chk({tag, "_hold_val"}, {16'd0, max_val}, {16'd0, ev});
            chk({tag, "_hold_idx"}, {27'd0, max_idx}, {27'd0, ei});
        end
    endtask

    initial begin
        logic [15:0] ev;
        logic [4:0]  ei;
        int k;

        tbl[0] = '0; tbl[0].len = 4; tbl[0].vprob = 100;
        tbl[0].d[0] = 16'd3; tbl[0].d[1] = 16'd9; tbl[0].d[2] = 16'd2; tbl[0].d[3] = 16'd7;
        tbl[0].ev = 16'd9; tbl[0].ei = 5'd1;
        tbl[1] = '0; tbl[1].len = 5; tbl[1].vprob = 100;
        tbl[1].d[0] = 16'd5; tbl[1].d[1] = 16'd8; tbl[1].d[2] = 16'd1; tbl[1].d[3] = 16'd8;
        tbl[1].d[4] = 16'd8;
        tbl[1].ev = 16'd8; tbl[1].ei = TIE_LAST ? 5'd4 : 5'd1;
        tbl[2] = '0; tbl[2].len = 0; tbl[2].vprob = 100; tbl[2].ev = 16'd0; tbl[2].ei = 5'd0;
        tbl[3] = '0; tbl[3].len = 1; tbl[3].vprob = 100;
        tbl[3].d[0] = 16'hFFFF; tbl[3].ev = 16'hFFFF; tbl[3].ei = 5'd0;
        tbl[4] = '0; tbl[4].len = 16; tbl[4].vprob = 50;
        for (int j = 0; j < 16; j++) tbl[4].d[j] = 16'(j);
        tbl[4].ev = 16'd15; tbl[4].ei = 5'd15;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_max_val", {16'd0, max_val}, 32'd0);
        chk("rst_max_idx", {27'd0, max_idx}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 5; n++) begin
            for (int j = 0; j < 32; j++) stim[j] = (j < 16) ? tbl[n].d[j] : 16'd0;
            run_and_check($sformatf("vec%0d", n), tbl[n].len, tbl[n].vprob, tbl[n].ev, tbl[n].ei);
        end

        // Abort with a start pulse ignored mid-run
        stim[0] = 16'd10; stim[1] = 16'd20; stim[2] = 16'd30;
        stim[3] = 16'd40; stim[4] = 16'd50; stim[5] = 16'd60;
        @(negedge clk);
        start = 1'b1; len = 5'd6;
        k = 0;
        for (int t = 0; t < 100 && k < 3; t++) begin
            @(negedge clk);
            start = (k == 2);
            len = 5'd1;
            in_valid = 1'b1;
            in_data = stim[k];
            if (in_ready) k++;
        end
        @(negedge clk);
        start = 1'b0;
        chk("abort_pre_val", {16'd0, max_val}, 32'd30);
        chk("abort_pre_idx", {27'd0, max_idx}, 32'd2);
        abort = 1'b1; in_valid = 1'b1; in_data = 16'd999;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd0);
        chk("abort_max_val", {16'd0, max_val}, 32'd0);
        chk("abort_max_idx", {27'd0, max_idx}, 32'd0);
        k = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) k++;
        end
        chk("abort_no_done", k, 0);
        stim[0] = 16'd4; stim[1] = 16'd1;
        run_and_check("after_abort", 2, 100, 16'd4, 5'd0);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        start = 1'b1; len = 5'd8;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 16'd500;
        repeat (3) @(negedge clk);
        chk("rstmid_pre_val", {16'd0, max_val}, 32'd500);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_ready", {31'd0, in_ready}, 32'd0);
        chk("rstmid_max_val", {16'd0, max_val}, 32'd0);
        chk("rstmid_max_idx", {27'd0, max_idx}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) k++;
        end
        in_valid = 1'b0;
        chk("rstmid_no_done", k, 0);

        // Random runs against the reference model
        for (int r = 0; r < 24; r++) begin
            int L, vp;
            L = int'($urandom_range(31));
            vp = (r % 3 == 0) ? 100 : int'($urandom_range(99, 30));
            for (int j = 0; j < 32; j++)
                stim[j] = (r % 2 == 0) ? 16'($urandom_range(7)) : 16'($urandom);
            model(L, ev, ei);
            run_and_check($sformatf("rand%0d", r), L, vp, ev, ei);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
